// File: rtl/fixed_gain_stage.sv
// Two-stage streaming gain: S1 captures sample+gain, S2 multiplies, saturates and holds the output beat.
// Optional CLIP_COUNT_EN adds a saturating 16-bit count of clipped output beats on port clip_count.
module fixed_gain_stage #(
    parameter int fractional_size = 12,
    parameter int operand_size    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [operand_size-1:0] gain_in,
    input  logic                    gain_load,
    input  logic [operand_size-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [operand_size-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_clip
`ifdef CLIP_COUNT_EN
    ,
    output logic [15:0]             clip_count
`endif
);

    localparam int W  = operand_size;
    localparam int PW = 2 * operand_size;
    localparam logic [W-1:0] MAX_C   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_C   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] UNITY_C = {{(W-1){1'b0}}, 1'b1} << fractional_size;

    // Full-precision signed product realigned to the Q format of the operands.
    function automatic logic signed [PW-1:0] fixed_multiply(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] b_ext;
        logic signed [PW-1:0] full;
        a_ext = $signed({{W{a[W-1]}}, a});
        b_ext = $signed({{W{b[W-1]}}, b});
        full  = a_ext * b_ext;
        return full >>> fractional_size;
    endfunction

    logic [W-1:0]          gain_r;
    logic                  s1_valid_r;
    logic [W-1:0]          s1_data_r;
    logic [W-1:0]          s1_gain_r;
    logic                  s1_adv_s;
    logic                  s2_adv_s;
    logic signed [PW-1:0]  prod_s;
    logic [W:0]            prod_top_s;
    logic [W-1:0]          sat_data_s;
    logic                  sat_clip_s;

    assign s2_adv_s = !out_valid || out_ready;
    assign s1_adv_s = !s1_valid_r || s2_adv_s;
    assign in_ready = s1_adv_s;

    // Multiply the S1 operands and clamp to the representable range.
    always_comb begin
        prod_s     = fixed_multiply(s1_data_r, s1_gain_r);
        prod_top_s = prod_s[PW-1:W-1];
        sat_data_s = prod_s[W-1:0];
        sat_clip_s = 1'b0;
        if ((&prod_top_s) || !(|prod_top_s)) begin
            sat_data_s = prod_s[W-1:0];
            sat_clip_s = 1'b0;
        end else if (prod_s[PW-1]) begin
            sat_data_s = MIN_C;
            sat_clip_s = 1'b1;
        end else begin
            sat_data_s = MAX_C;
            sat_clip_s = 1'b1;
        end
    end

    // Gain register; a sample accepted this cycle already latched the old value into S1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_r <= UNITY_C;
        end else if (gain_load) begin
            gain_r <= gain_in;
        end else begin
            gain_r <= gain_r;
        end
    end

    // Stage 1: capture the sample together with the gain in force at transfer time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {W{1'b0}};
            s1_gain_r  <= UNITY_C;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r <= in_data;
                s1_gain_r <= gain_r;
            end else begin
                s1_data_r <= s1_data_r;
                s1_gain_r <= s1_gain_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: registered output beat, frozen while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {W{1'b0}};
            out_clip  <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_data <= sat_data_s;
                out_clip <= sat_clip_s;
            end else begin
                out_data <= out_data;
                out_clip <= 1'b0;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

`ifdef CLIP_COUNT_EN
    // Count clipped beats as they leave; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count <= 16'h0000;
        end else if (out_valid && out_ready && out_clip && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end else begin
            clip_count <= clip_count;
        end
    end
`endif

endmodule
